data_mem_io_ctrl: RTL and testbench
===================================

Name: data_mem_io_ctrl

Overview:
- Parametrised data-side memory and MMIO controller between the ARM core's data port and on-chip storage.
- Replaces the single-cycle combinational data decode with a registered, wait-state-configurable access FSM and a Stall handshake.
- Adds byte-enable writes, a read-only constant region, a memory-mapped IO page (LED, seven-seg, DIP, cycle counter), and sticky address-error reporting.
- Instruction memory stays outside this block.

Parameters:
DEPTH_WORDS, 128, words in each of the CONST and VAR regions (power of 2, 16..1024)
CONST_BASE, 32'h00000200, byte base of the read-only constant region
VAR_BASE, 32'h00000800, byte base of the read/write variable region
IO_BASE, 32'h00000C00, byte base of the 16-byte IO page
WAIT_STATES, 1, extra stall cycles per access (0..15)
N_LEDs, 16, LED output width (1..32)
N_DIPs, 7, DIP input width (1..32)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
MemRead  in  1  read request; held stable by the core while Stall=1
MemWrite  in  1  write request; held stable while Stall=1; MemRead&MemWrite together = write
ByteEn  in  4  byte lane enables for VAR writes; bit i -> WriteData[8i+7:8i]
ALUResult  in  32  byte address
WriteData  in  32  store data
ReadData  out  32  load data; valid only in the cycle Stall drops
Stall  out  1  high while an accepted access is in progress
DIP  in  N_DIPs  switch inputs
LED  out  N_LEDs  LED register, low bits
SEVENSEGHEX  out  32  seven-segment register
AddrErr  out  1  sticky error flag
ErrAddr  out  32  address of the first faulting access

Behaviour:
- Regions, each of size DEPTH_WORDS*4 bytes:
  - CONST: [CONST_BASE, CONST_BASE+4*DEPTH_WORDS-4]; index = addr[log2(DEPTH_WORDS)+1:2].
  - VAR: same form from VAR_BASE.
  - IO: [IO_BASE, IO_BASE+12].
  - Anything else is unmapped.
- IO page:
  - +0: LED register, RW; LED = reg[N_LEDs-1:0].
  - +4: SEVENSEG register, RW.
  - +8: DIP, RO; zero-extended, sampled at the DONE edge.
  - +C: CYCLE, RO; free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0.
  - IO writes ignore ByteEn and write the full word.
- CONST contents come from an init file at elaboration. CONST and VAR contents are not cleared by RESET.
- FSM has three states: IDLE, WAIT, DONE.
  - IDLE with a request: if WAIT_STATES>0 go to WAIT and load cnt=WAIT_STATES-1; else go to DONE.
  - WAIT: cnt decrements each cycle; at cnt==0 go to DONE.
  - DONE: always return to IDLE.
- Stall = request & (state != DONE). The core therefore sees exactly WAIT_STATES+1 stall cycles per access.
- The read mux is registered on entry to DONE, so ReadData is stable throughout DONE.
- Writes commit on the DONE->IDLE edge only.
- In DONE the core advances. A new request is accepted in the following IDLE cycle; back-to-back requests cost 1 cycle of IDLE stall plus the wait states.
- A request dropped mid-access (protocol violation) returns the FSM to IDLE with no write.
- Errors are detected on entry to DONE:
  - Conditions: misaligned (addr[1:0]!=0), unmapped, write to CONST, or write to IO+8 / IO+C.
  - Effect: write suppressed, ReadData=0, AddrErr set.
  - ErrAddr captured only if AddrErr was 0 (first fault wins).
  - AddrErr clears only on RESET.
- Byte-enabled VAR write: only the enabled lanes change. ByteEn=0 is a legal no-op write.
- Reset values:
  - state=IDLE; ReadData, LED reg, SEVENSEG reg, CYCLE, AddrErr, ErrAddr all 0.
  - Stall is 0 in the reset cycle.
  - RESET mid-access aborts it; no write commits.
- Exact region boundaries are inclusive. The address one word past a region end is unmapped.

Test Plan:
- WAIT_STATES=1, CONST[5]=3: read 0x214 -> Stall high 2 cycles, ReadData=0x00000003 in DONE, no AddrErr.
- Write 0xAABBCCDD to 0x800 with ByteEn=0xF, then ByteEn=0x2 with WriteData 0x00001100, read 0x800 -> 0xAABB11DD.
- Write 0x1234 to IO+0 -> LED=0x1234 after commit edge; write IO+4 = 0xDEADBEEF -> SEVENSEGHEX=0xDEADBEEF; DIP=7'h55, read IO+8 -> 0x00000055.
- Write to 0x200 (CONST), then read 0x1000 (unmapped) -> CONST unchanged, AddrErr=1, ErrAddr=0x200 (not overwritten), both reads of 0x1000 return 0.
- Boundaries: read 0x9FC -> VAR[127]; read 0xA00 -> 0 with AddrErr; read 0x802 -> misaligned, AddrErr.
- Assert RESET in WAIT during a write of 0x55 to 0x804 -> VAR[1] unchanged, Stall=0, state IDLE, LED/SEVENSEG/CYCLE=0; repeat all with WAIT_STATES=0 (1 stall cycle each).

Source files
------------

// File: rtl/data_mem_io_ctrl_if.sv
// rtl/data_mem_io_ctrl_if.sv - core data-port bus between the ARM core and data_mem_io_ctrl
interface data_mem_io_ctrl_if;
    logic        MemRead;
    logic        MemWrite;
    logic [3:0]  ByteEn;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;

    modport master (
        output MemRead, MemWrite, ByteEn, ALUResult, WriteData,
        input  ReadData, Stall
    );

    modport slave (
        input  MemRead, MemWrite, ByteEn, ALUResult, WriteData,
        output ReadData, Stall
    );
endinterface

// File: rtl/data_mem_io_ctrl.sv
// rtl/data_mem_io_ctrl.sv - wait-state data memory / MMIO controller with sticky address-error capture
module data_mem_io_ctrl #(
    parameter int                        DEPTH_WORDS = 128,
    parameter logic [31:0]               CONST_BASE  = 32'h0000_0200,
    parameter logic [31:0]               VAR_BASE    = 32'h0000_0800,
    parameter logic [31:0]               IO_BASE     = 32'h0000_0C00,
    parameter int                        WAIT_STATES = 1,
    parameter int                        N_LEDs      = 16,
    parameter int                        N_DIPs      = 7,
    parameter logic [32*DEPTH_WORDS-1:0] CONST_INIT  = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    data_mem_io_ctrl_if.slave bus,
    input  logic [N_DIPs-1:0] DIP,
    output logic [N_LEDs-1:0] LED,
    output logic [31:0]       SEVENSEGHEX,
    output logic              AddrErr,
    output logic [31:0]       ErrAddr
);
    localparam int          AW           = $clog2(DEPTH_WORDS);
    localparam logic [31:0] REGION_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   rdata_q;
    logic [31:0]   led_q;
    logic [31:0]   seg_q;
    logic [31:0]   cycle_q;
    logic [31:0]   err_addr_q;
    logic          addr_err_q;
    logic          acc_err_q;
    logic [31:0]   var_mem [DEPTH_WORDS];

    logic          req;
    logic          is_wr;
    logic [31:0]   addr;
    logic [31:0]   off_const;
    logic [31:0]   off_var;
    logic [31:0]   off_io;
    logic          in_const;
    logic          in_var;
    logic          in_io;
    logic          fault;
    logic [AW-1:0] idx;
    logic [31:0]   rdata_d;
    logic          enter_done;
    logic          commit;

    assign req       = bus.MemRead | bus.MemWrite;
    assign is_wr     = bus.MemWrite;
    assign addr      = bus.ALUResult;
    assign idx       = addr[AW+1:2];
    assign off_const = addr - CONST_BASE;
    assign off_var   = addr - VAR_BASE;
    assign off_io    = addr - IO_BASE;
    assign in_const  = (addr >= CONST_BASE) && (off_const < REGION_BYTES);
    assign in_var    = (addr >= VAR_BASE) && (off_var < REGION_BYTES);
    assign in_io     = (addr >= IO_BASE) && (off_io < 32'd16);

    // IO+8 (DIP) and IO+C (CYCLE) are read-only, so stores there fault
    assign fault = (addr[1:0] != 2'b00)
                 | ~(in_const | in_var | in_io)
                 | (is_wr & in_const)
                 | (is_wr & in_io & addr[3]);

    always_comb begin
        rdata_d = '0;
        if (in_const) begin
            rdata_d = CONST_INIT[32*int'(idx) +: 32];
        end else if (in_var) begin
            rdata_d = var_mem[idx];
        end else if (in_io) begin
            case (addr[3:2])
                2'd0:    rdata_d = led_q;
                2'd1:    rdata_d = seg_q;
                2'd2:    rdata_d = 32'(DIP);
                default: rdata_d = cycle_q;
            endcase
        end
        if (fault) begin
            rdata_d = '0;
        end
    end

    assign enter_done = req && (((state_q == S_IDLE) && (WAIT_STATES == 0)) ||
                                ((state_q == S_WAIT) && (cnt_q == 4'd0)));
    // The core holds address and data through DONE, so the commit uses the live bus
    assign commit     = (state_q == S_DONE) && req && is_wr && !acc_err_q && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            led_q      <= '0;
            seg_q      <= '0;
            cycle_q    <= '0;
            err_addr_q <= '0;
            addr_err_q <= 1'b0;
            acc_err_q  <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (enter_done) begin
                rdata_q   <= rdata_d;
                acc_err_q <= fault;
                if (fault) begin
                    addr_err_q <= 1'b1;
                    if (!addr_err_q) begin
                        err_addr_q <= addr;
                    end
                end
            end
            if (commit && in_io) begin
                if (addr[3:2] == 2'd0) begin
                    led_q <= bus.WriteData;
                end else if (addr[3:2] == 2'd1) begin
                    seg_q <= bus.WriteData;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (WAIT_STATES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage has no reset so it maps onto plain RAM
    always_ff @(posedge CLK) begin
        if (commit && in_var) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ByteEn[b]) begin
                    var_mem[idx][8*b +: 8] <= bus.WriteData[8*b +: 8];
                end
            end
        end
    end

    assign bus.Stall    = req & (state_q != S_DONE) & ~RESET;
    assign bus.ReadData = rdata_q;
    assign LED          = led_q[N_LEDs-1:0];
    assign SEVENSEGHEX  = seg_q;
    assign AddrErr      = addr_err_q;
    assign ErrAddr      = err_addr_q;
endmodule

// File: tb/tb_data_mem_io_ctrl.sv
// tb/tb_data_mem_io_ctrl.sv - directed bench for data_mem_io_ctrl at WAIT_STATES 1 and 0
module tb_data_mem_io_ctrl;
    localparam logic [4095:0] CINIT = (4096'(32'h7F7F_7F7F) << (127*32))
                                    | (4096'(32'h0000_0003) << (5*32))
                                    | 4096'(32'hC0DE_0000);

    logic        CLK;
    logic        RESET;
    logic        sel;
    logic        rd, wr;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [6:0]  dip;
    int          n_cmp, n_fail, ws;

    data_mem_io_ctrl_if if0();
    data_mem_io_ctrl_if if1();

    assign if0.MemRead   = rd & ~sel;
    assign if0.MemWrite  = wr & ~sel;
    assign if0.ByteEn    = be;
    assign if0.ALUResult = addr;
    assign if0.WriteData = wdata;
    assign if1.MemRead   = rd & sel;
    assign if1.MemWrite  = wr & sel;
    assign if1.ByteEn    = be;
    assign if1.ALUResult = addr;
    assign if1.WriteData = wdata;

    logic [15:0] led0, led1;
    logic [31:0] seg0, seg1, ea0, ea1;
    logic        ae0, ae1;

    data_mem_io_ctrl #(.WAIT_STATES(1), .CONST_INIT(CINIT)) u_ws1 (
        .CLK(CLK), .RESET(RESET), .bus(if0), .DIP(dip), .LED(led0),
        .SEVENSEGHEX(seg0), .AddrErr(ae0), .ErrAddr(ea0)
    );
    data_mem_io_ctrl #(.WAIT_STATES(0), .CONST_INIT(CINIT)) u_ws0 (
        .CLK(CLK), .RESET(RESET), .bus(if1), .DIP(dip), .LED(led1),
        .SEVENSEGHEX(seg1), .AddrErr(ae1), .ErrAddr(ea1)
    );

    wire        stall = sel ? if1.Stall    : if0.Stall;
    wire [31:0] rdata = sel ? if1.ReadData : if0.ReadData;
    wire [15:0] led   = sel ? led1 : led0;
    wire [31:0] seg   = sel ? seg1 : seg0;
    wire        aerr  = sel ? ae1  : ae0;
    wire [31:0] eaddr = sel ? ea1  : ea0;

    always #5 CLK = ~CLK;

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] q, output int n);
        rd = ~w; wr = w; addr = a; wdata = d; be = b; n = 0;
        #1;
        while (stall && n < 40) begin
            n++;
            @(negedge CLK);
            #1;
        end
        if (stall) begin
            n_cmp++; n_fail++;
            $display("FAIL access_timeout ws=%0d addr=%h got stall stuck, want drop", ws, a);
        end
        q = rdata;
        @(negedge CLK);
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1; rd = 1'b1; addr = 32'h214;
        @(negedge CLK); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall ws=%0d got %b want 0", ws, stall); end
        @(negedge CLK);
        rd = 1'b0; RESET = 1'b0;
        #1;
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata ws=%0d got %h want 0", ws, rdata); end
        n_cmp++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led ws=%0d got %h want 0", ws, led); end
        n_cmp++; if (seg !== 32'h0) begin n_fail++; $display("FAIL reset_seg ws=%0d got %h want 0", ws, seg); end
        n_cmp++; if (aerr !== 1'b0) begin n_fail++; $display("FAIL reset_aerr ws=%0d got %b want 0", ws, aerr); end
        n_cmp++; if (eaddr !== 32'h0) begin n_fail++; $display("FAIL reset_eaddr ws=%0d got %h want 0", ws, eaddr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        int n1, n2;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        access(1'b0, 32'hC0C, 32'h0, 4'h0, d1, n1);
        access(1'b0, 32'hC0C, 32'h0, 4'h0, d2, n2);
        n_cmp++; if (d1 !== 32'(ws)) begin n_fail++; $display("FAIL cycle_first ws=%0d got %h want %h", ws, d1, ws); end
        n_cmp++; if (d2 - d1 !== 32'(ws + 2)) begin n_fail++; $display("FAIL cycle_delta ws=%0d got %0d want %0d", ws, d2 - d1, ws + 2); end
        n_cmp++; if (n2 !== ws + 1) begin n_fail++; $display("FAIL b2b_stalls ws=%0d got %0d want %0d", ws, n2, ws + 1); end
    endtask

    task automatic test_const_read();
        logic [31:0] q;
        int n;
        access(1'b0, 32'h214, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h3) begin n_fail++; $display("FAIL const5 ws=%0d got %h want 3", ws, q); end
        n_cmp++; if (n !== ws + 1) begin n_fail++; $display("FAIL const_stalls ws=%0d got %0d want %0d", ws, n, ws + 1); end
        access(1'b0, 32'h3FC, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h7F7F7F7F) begin n_fail++; $display("FAIL const127 ws=%0d got %h want 7f7f7f7f", ws, q); end
        n_cmp++; if (aerr !== 1'b0) begin n_fail++; $display("FAIL const_aerr ws=%0d got %b want 0", ws, aerr); end
    endtask

    task automatic test_byte_en();
        logic [31:0] q;
        int n;
        access(1'b1, 32'h800, 32'hAABBCCDD, 4'hF, q, n);
        access(1'b1, 32'h800, 32'h00001100, 4'h2, q, n);
        access(1'b0, 32'h800, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'hAABB11DD) begin n_fail++; $display("FAIL byte_en ws=%0d got %h want aabb11dd", ws, q); end
        access(1'b1, 32'h800, 32'hFFFFFFFF, 4'h0, q, n);
        access(1'b0, 32'h800, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'hAABB11DD) begin n_fail++; $display("FAIL byte_en_zero ws=%0d got %h want aabb11dd", ws, q); end
        access(1'b1, 32'h9FC, 32'h0BADF00D, 4'hF, q, n);
        access(1'b0, 32'h9FC, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h0BADF00D) begin n_fail++; $display("FAIL var_top ws=%0d got %h want 0badf00d", ws, q); end
        n_cmp++; if (aerr !== 1'b0) begin n_fail++; $display("FAIL var_aerr ws=%0d got %b want 0", ws, aerr); end
    endtask

    task automatic test_io();
        logic [31:0] q;
        int n;
        access(1'b1, 32'hC00, 32'h00001234, 4'h0, q, n);
        n_cmp++; if (led !== 16'h1234) begin n_fail++; $display("FAIL io_led ws=%0d got %h want 1234", ws, led); end
        access(1'b1, 32'hC04, 32'hDEADBEEF, 4'h1, q, n);
        n_cmp++; if (seg !== 32'hDEADBEEF) begin n_fail++; $display("FAIL io_seg ws=%0d got %h want deadbeef", ws, seg); end
        dip = 7'h55;
        access(1'b0, 32'hC08, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h55) begin n_fail++; $display("FAIL io_dip ws=%0d got %h want 55", ws, q); end
        access(1'b0, 32'hC00, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h1234) begin n_fail++; $display("FAIL io_led_rd ws=%0d got %h want 1234", ws, q); end
    endtask

    task automatic test_errors();
        logic [31:0] q;
        int n;
        access(1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, q, n);
        n_cmp++; if (aerr !== 1'b1) begin n_fail++; $display("FAIL err_const_wr ws=%0d got %b want 1", ws, aerr); end
        n_cmp++; if (eaddr !== 32'h200) begin n_fail++; $display("FAIL err_addr ws=%0d got %h want 200", ws, eaddr); end
        access(1'b0, 32'h200, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'hC0DE0000) begin n_fail++; $display("FAIL const_kept ws=%0d got %h want c0de0000", ws, q); end
        access(1'b0, 32'h1000, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h0) begin n_fail++; $display("FAIL unmapped1 ws=%0d got %h want 0", ws, q); end
        access(1'b0, 32'h1000, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h0) begin n_fail++; $display("FAIL unmapped2 ws=%0d got %h want 0", ws, q); end
        access(1'b0, 32'hA00, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h0) begin n_fail++; $display("FAIL var_past_end ws=%0d got %h want 0", ws, q); end
        access(1'b0, 32'h400, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h0) begin n_fail++; $display("FAIL const_past_end ws=%0d got %h want 0", ws, q); end
        access(1'b0, 32'h802, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h0) begin n_fail++; $display("FAIL misaligned ws=%0d got %h want 0", ws, q); end
        n_cmp++; if (eaddr !== 32'h200) begin n_fail++; $display("FAIL err_first_wins ws=%0d got %h want 200", ws, eaddr); end
    endtask

    task automatic test_abort_reset();
        logic [31:0] q;
        int n;
        access(1'b1, 32'h804, 32'h11112222, 4'hF, q, n);
        rd = 1'b0; wr = 1'b1; addr = 32'h804; wdata = 32'h55; be = 4'hF;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall ws=%0d got %b want 0", ws, stall); end
        @(negedge CLK);
        wr = 1'b0; RESET = 1'b0;
        #1;
        n_cmp++; if (led !== 16'h0) begin n_fail++; $display("FAIL abort_led ws=%0d got %h want 0", ws, led); end
        n_cmp++; if (seg !== 32'h0) begin n_fail++; $display("FAIL abort_seg ws=%0d got %h want 0", ws, seg); end
        n_cmp++; if (aerr !== 1'b0) begin n_fail++; $display("FAIL abort_aerr ws=%0d got %b want 0", ws, aerr); end
        access(1'b0, 32'h804, 32'h0, 4'h0, q, n);
        n_cmp++; if (q !== 32'h11112222) begin n_fail++; $display("FAIL abort_var1 ws=%0d got %h want 11112222", ws, q); end
        n_cmp++; if (n !== ws + 1) begin n_fail++; $display("FAIL abort_idle ws=%0d got %0d want %0d", ws, n, ws + 1); end
        access(1'b0, 32'h802, 32'h0, 4'h0, q, n);
        n_cmp++; if (eaddr !== 32'h802) begin n_fail++; $display("FAIL misalign_first ws=%0d got %h want 802", ws, eaddr); end
        n_cmp++; if (aerr !== 1'b1) begin n_fail++; $display("FAIL misalign_aerr ws=%0d got %b want 1", ws, aerr); end
    endtask

    initial begin
        CLK = 1'b0; RESET = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0;
        be = 4'h0; addr = 32'h0; wdata = 32'h0; dip = 7'h00;
        n_cmp = 0; n_fail = 0; ws = 1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            ws  = (s == 0) ? 1 : 0;
            test_reset();
            test_back_to_back();
            test_const_read();
            test_byte_en();
            test_io();
            test_errors();
            test_abort_reset();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
